// File: rtl/product_accumulator_if.sv
// Product accumulator bus: product input handshake plus frame-result output handshake.
//   slave  : the accumulator side (consumes products, produces results)
//   master : the producer/consumer side driving products and taking results
// Signals:
//   in_valid/in_ready/prod_in          product handshake (prod_in is an unsigned 6-bit product)
//   out_valid/out_ready/out_sum/out_ovf result handshake
//   term_cnt                           products accepted in the current frame
interface product_accumulator_if #(
  parameter int unsigned N_TERMS = 4,
  parameter int unsigned ACC_W   = 8
);
  localparam int unsigned CW = $clog2(N_TERMS);

  logic             in_valid;
  logic             in_ready;
  logic [5:0]       prod_in;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic             out_ovf;
  logic [CW-1:0]    term_cnt;

  modport slave (
    input  in_valid, prod_in, out_ready,
    output in_ready, out_valid, out_sum, out_ovf, term_cnt
  );

  modport master (
    output in_valid, prod_in, out_ready,
    input  in_ready, out_valid, out_sum, out_ovf, term_cnt
  );
endinterface

// File: rtl/product_accumulator.sv
// Sums N_TERMS consecutive 6-bit unsigned products into one frame result and holds the
// result on a valid/ready port until it is taken.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   clr  - synchronous frame abort (highest priority, drops any partial or held frame)
//   bus  - product_accumulator_if.slave: product input handshake, result output handshake,
//          term_cnt (products accepted this frame)
// Configuration:
//   SATURATE_EN defined   : accumulator clamps to 2^ACC_W-1 on overflow for the rest of the frame
//   SATURATE_EN undefined : accumulator wraps modulo 2^ACC_W
//   In both cases out_ovf flags that the frame sum exceeded 2^ACC_W-1.
module product_accumulator #(
  parameter int unsigned N_TERMS = 4,
  parameter int unsigned ACC_W   = 8
) (
  input logic                  clk,
  input logic                  rst,
  input logic                  clr,
  product_accumulator_if.slave bus
);
  localparam int unsigned   CW      = $clog2(N_TERMS);
  localparam int unsigned   SW      = ACC_W + 1;
  localparam logic [CW-1:0] LastCnt = CW'(N_TERMS - 1);

  typedef enum logic {StAcc, StDone} state_e;

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [SW-1:0]    sum_ext;

  // One extra bit so the carry out of the accumulator is visible.
  assign sum_ext = {1'b0, acc_q} + SW'(bus.prod_in);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    if (clr) begin
      state_d = StAcc;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        StAcc: begin
          // in_ready is 1 throughout StAcc, so in_valid alone qualifies the accept.
          if (bus.in_valid) begin
`ifdef SATURATE_EN
            // Once clamped, stay clamped until the frame ends.
            acc_d = (sum_ext[ACC_W] || ovf_q) ? '1 : sum_ext[ACC_W-1:0];
`else
            acc_d = sum_ext[ACC_W-1:0];
`endif
            if (sum_ext[ACC_W]) ovf_d = 1'b1;
            // The completing accept leaves cnt at N_TERMS-1.
            if (cnt_q == LastCnt) begin
              state_d = StDone;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
        StDone: begin
          if (bus.out_ready) begin
            state_d = StAcc;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
          end
        end
        default: state_d = StAcc;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StAcc;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.in_ready  = (state_q == StAcc);
  assign bus.out_valid = (state_q == StDone);
  assign bus.out_sum   = acc_q;
  assign bus.out_ovf   = ovf_q;
  assign bus.term_cnt  = cnt_q;
endmodule
